pwm_compare_out: RTL and testbench
==================================

Name: pwm_compare_out

Overview:
- Output stage directly downstream of the PWM period counter.
- Consumes the counter value and the period, compares them against double-buffered compare/function settings from the register file, and drives the registered PWM pin.
- Compare settings are shadowed so a register write never changes the waveform mid-period; new values take effect at the next period boundary.
- Also emits a one-cycle period event for the interrupt/status logic.

Parameters:
- WIDTH, 16, width of count_val, period, compare1, compare2.

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  reset, asynchronous, active-low.
- count_val  input  WIDTH  current counter value; may change at most once per clk.
- period  input  WIDTH  counter period (terminal value is period-1).
- upnotdown  input  1  counter direction: 1 = up, 0 = down.
- pwm_en  input  1  output enable.
- functions  input  2  mode: 00 left-aligned, 01 right-aligned, 10 range-between, 11 reserved.
- compare1  input  WIDTH  first compare value.
- compare2  input  WIDTH  second compare value, used by range mode only.
- polarity  input  1  1 inverts the output.
- cfg_load  input  1  single-cycle strobe; capture compare1/compare2/functions/polarity into pending.
- pwm_out  output  1  registered PWM output.
- period_evt  output  1  one-cycle pulse per period boundary.
- cfg_pending  output  1  pending config not yet applied.

Behaviour:
- Reset (asynchronous):
  - pwm_out=0, period_evt=0, cfg_pending=0.
  - prev_cnt=0; all pending and active config registers = 0.
- Internal registers:
  - prev_cnt samples count_val every clk.
  - Pending set: pend_cmp1, pend_cmp2, pend_func, pend_pol.
  - Active set: act_cmp1, act_cmp2, act_func, act_pol.
- start = upnotdown ? 0 : period-1, computed modulo 2^WIDTH.
- boundary = pwm_en && (count_val != prev_cnt) && (count_val == start).
- en_rise = pwm_en && !pwm_en_q, where pwm_en_q is pwm_en registered.
- cfg_load: captures the config inputs into the pending set and sets cfg_pending. A later cfg_load before the boundary overwrites the pending set (last write wins).
- Effective config for the current cycle, in priority order:
  - pwm_en=0: the input ports directly. The active set is loaded from the ports every cycle and cfg_pending is cleared.
  - boundary or en_rise, with cfg_load in the same cycle: the input ports.
  - boundary or en_rise, with cfg_pending=1: the pending set.
  - Otherwise: the active set.
- On boundary or en_rise: the effective config is written into the active set and cfg_pending is cleared. A cfg_load in the same cycle is consumed by this update and does not leave cfg_pending set.
- Raw compare, using c = count_val and the effective config:
  - Left (00): raw = c < cmp1. cmp1=0 gives a constant 0; cmp1 >= period gives a constant 1.
  - Right (01): raw = c >= cmp1.
  - Range (10): raw = (cmp1 <= c) && (c < cmp2). cmp1 >= cmp2 gives raw = 0.
  - Reserved (11): raw = 0.
  - All comparisons are unsigned and full WIDTH.
- Output: next pwm_out = pwm_en && (period != 0) ? raw ^ pol : pol.
  - Latency: exactly 1 clk from count_val to pwm_out.
  - When disabled, the pin sits at the inactive level = effective polarity.
- period_evt: next value = boundary && (period != 0). Asserted for exactly one clk, one cycle after count_val reaches start. Never asserted while pwm_en=0.
- Counter held (count_val stable, e.g. prescaler gap or count_reset held): no new boundary and no extra period_evt. pwm_out stays constant for the stable value.
- Wrap in down mode with period=1: start=0 and count_val is always 0, so no change is detected and no boundary occurs. Config only loads on en_rise or while disabled.
- Switching upnotdown mid-period: start changes immediately. No other side effects.
- Asynchronous reset mid-period: everything clears immediately. The first boundary after release behaves normally.

Test Plan:
- Basic left-aligned PWM: period=10, up, functions=00, cmp1=3, polarity=0, pwm_en=1, count_val 0..9 repeating → pwm_out=1 for count_val 0,1,2 and 0 for 3..9, delayed one clk. period_evt pulses once per 10 counts, one cycle after count_val=0.
- Shadow update: mid-period cfg_load with cmp1=7 while count_val=5 → waveform unchanged until count_val wraps to 0; cfg_pending=1 meanwhile. Next period: high for counts 0..6, cfg_pending=0.
- Simultaneous cfg_load with boundary: cfg_load cmp1=2 in the same cycle count_val becomes 0 → new value used from count 0 onward; cfg_pending stays 0.
- Range and down mode:
  - functions=10, cmp1=4, cmp2=8, down count 9..0 → pwm_out=1 only for counts 7..4.
  - cmp1=8, cmp2=4 → pwm_out constant 0.
- Disable and polarity: polarity=1, pwm_en=0 → pwm_out=1 and no period_evt. Then pwm_en=1 with cmp1=0 in left mode → pwm_out=1 (raw 0 inverted).
- Held counter and reset: count_val frozen at 0 for 5 clks → exactly one period_evt. Assert rst_n=0 mid-period → pwm_out, period_evt and cfg_pending drop to 0 asynchronously.

Source files
------------

// File: rtl/pwm_compare_out_if.sv
// Bundle between the PWM period counter / register file and the compare output stage.
interface pwm_compare_out_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] count_val;
  logic [WIDTH-1:0] period;
  logic             upnotdown;
  logic             pwm_en;
  logic [1:0]       functions;
  logic [WIDTH-1:0] compare1;
  logic [WIDTH-1:0] compare2;
  logic             polarity;
  logic             cfg_load;
  logic             pwm_out;
  logic             period_evt;
  logic             cfg_pending;

  modport master (
    output count_val, period, upnotdown, pwm_en, functions,
           compare1, compare2, polarity, cfg_load,
    input  pwm_out, period_evt, cfg_pending
  );

  modport slave (
    input  count_val, period, upnotdown, pwm_en, functions,
           compare1, compare2, polarity, cfg_load,
    output pwm_out, period_evt, cfg_pending
  );
endinterface

// File: rtl/pwm_compare_out.sv
// PWM compare output stage: double-buffered compare config, registered pin,
// one-cycle period event at each counter period boundary.
module pwm_compare_out #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_compare_out_if.slave   bus
);

  typedef enum logic [1:0] {
    FN_LEFT  = 2'b00,
    FN_RIGHT = 2'b01,
    FN_RANGE = 2'b10,
    FN_RSVD  = 2'b11
  } func_e;

  typedef struct packed {
    logic [WIDTH-1:0] cmp1;
    logic [WIDTH-1:0] cmp2;
    func_e            func;
    logic             pol;
  } cfg_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] prev_cnt;
  logic             pwm_en_q;
  cfg_t             pend_cfg;
  cfg_t             act_cfg;
  logic             cfg_pending_q;
  logic             pwm_q;
  logic             evt_q;

  cfg_t             port_cfg;
  cfg_t             eff_cfg;
  logic [WIDTH-1:0] start;
  logic             boundary;
  logic             en_rise;
  logic             update;
  logic             raw;
  logic             period_nz;

  // Boundary/enable-edge detection and selection of the config in force this cycle.
  always_comb begin
    port_cfg  = '{cmp1: bus.compare1, cmp2: bus.compare2,
                  func: func_e'(bus.functions), pol: bus.polarity};
    start     = bus.upnotdown ? '0 : (bus.period - ONE);
    boundary  = bus.pwm_en && (bus.count_val != prev_cnt) && (bus.count_val == start);
    en_rise   = bus.pwm_en && !pwm_en_q;
    update    = boundary || en_rise;
    period_nz = |bus.period;
    if (!bus.pwm_en)               eff_cfg = port_cfg;
    else if (update && bus.cfg_load) eff_cfg = port_cfg;
    else if (update && cfg_pending_q) eff_cfg = pend_cfg;
    else                           eff_cfg = act_cfg;
  end

  // Raw compare of the live counter value against the effective config.
  always_comb begin
    raw = 1'b0;
    unique case (eff_cfg.func)
      FN_LEFT:  raw = bus.count_val < eff_cfg.cmp1;
      FN_RIGHT: raw = bus.count_val >= eff_cfg.cmp1;
      FN_RANGE: raw = (bus.count_val >= eff_cfg.cmp1) && (bus.count_val < eff_cfg.cmp2);
      FN_RSVD:  raw = 1'b0;
    endcase
  end

  // Counter/enable history, shadow config registers and registered outputs.
  // A cfg_load coinciding with an update goes straight to the active set, so
  // the pending flag is cleared rather than set in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt      <= '0;
      pwm_en_q      <= 1'b0;
      pend_cfg      <= '0;
      act_cfg       <= '0;
      cfg_pending_q <= 1'b0;
      pwm_q         <= 1'b0;
      evt_q         <= 1'b0;
    end else begin
      prev_cnt <= bus.count_val;
      pwm_en_q <= bus.pwm_en;
      if (bus.cfg_load) pend_cfg <= port_cfg;
      if (!bus.pwm_en || update) begin
        act_cfg       <= eff_cfg;
        cfg_pending_q <= 1'b0;
      end else if (bus.cfg_load) begin
        cfg_pending_q <= 1'b1;
      end
      pwm_q <= (bus.pwm_en && period_nz) ? (raw ^ eff_cfg.pol) : eff_cfg.pol;
      evt_q <= boundary && period_nz;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_evt  = evt_q;
  assign bus.cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_pwm_compare_out.sv
// Self-checking bench for pwm_compare_out: directed scenarios plus random
// traffic, checked against a behavioural model of the shadowed compare rules.
module tb_pwm_compare_out;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_compare_out_if #(.WIDTH(W)) bus ();

  pwm_compare_out #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned c1;
    int unsigned c2;
    int unsigned fn;
    bit          pol;
  } mcfg_t;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // model state
  int unsigned m_prev;
  bit          m_en_q;
  mcfg_t       m_pend, m_act;
  bit          m_pending;
  bit          m_pwm, m_evt;

  function automatic bit ideal_wave(int unsigned fn, int unsigned c, int unsigned c1, int unsigned c2);
    case (fn)
      0: return c < c1;
      1: return c >= c1;
      2: return (c >= c1) && (c < c2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_vec();
    return {m_pwm, m_evt, m_pending};
  endfunction

  task automatic model_reset();
    m_prev = 0; m_en_q = 0; m_pending = 0; m_pwm = 0; m_evt = 0;
    m_pend = '{0, 0, 0, 1'b0};
    m_act  = '{0, 0, 0, 1'b0};
  endtask

  // One clock of the reference: what the pin/event/pending should look like after the edge.
  task automatic model_step();
    mcfg_t port, eff;
    int unsigned per, cnt, strt;
    bit new_period, first_on, refresh;
    per  = int'(bus.period);
    cnt  = int'(bus.count_val);
    port = '{int'(bus.compare1), int'(bus.compare2), int'(bus.functions), bus.polarity};
    strt = bus.upnotdown ? 0 : ((per + 65535) % 65536);
    new_period = bus.pwm_en && (cnt != m_prev) && (cnt == strt);
    first_on   = bus.pwm_en && !m_en_q;
    refresh    = new_period || first_on;
    if (!bus.pwm_en || (refresh && bus.cfg_load)) eff = port;
    else if (refresh && m_pending)                 eff = m_pend;
    else                                           eff = m_act;
    m_pwm = (bus.pwm_en && per != 0) ? (ideal_wave(eff.fn, cnt, eff.c1, eff.c2) ^ eff.pol) : eff.pol;
    m_evt = new_period && (per != 0);
    if (bus.cfg_load) m_pend = port;
    if (!bus.pwm_en || refresh) begin m_act = eff; m_pending = 0; end
    else if (bus.cfg_load) m_pending = 1;
    m_prev = cnt;
    m_en_q = bus.pwm_en;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.count_val = '0; bus.period = 16'd10; bus.upnotdown = 1'b1; bus.pwm_en = 1'b0;
    bus.functions = 2'b00; bus.compare1 = 16'd3; bus.compare2 = '0; bus.polarity = 1'b0;
    bus.cfg_load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.pwm_out, bus.period_evt, bus.cfg_pending} !== 3'b000)
      $display("FAIL reset_state: got %b expected 000", {bus.pwm_out, bus.period_evt, bus.cfg_pending});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_left_basic();
    int unsigned evts = 0;
    bus.count_val = 16'd9;
    repeat (2) tick();
    bus.pwm_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        bus.count_val = 16'(c);
        tick();
        if (bus.period_evt === 1'b1) evts++;
        total_cnt++;
        if ({bus.pwm_out, bus.period_evt} !== {1'(c < 3), 1'(c == 0)})
          $display("FAIL left_basic c=%0d: got %b expected %b", c, {bus.pwm_out, bus.period_evt}, {1'(c < 3), 1'(c == 0)});
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (evts != 3) $display("FAIL left_evt_count: got %0d expected 3", evts);
    else pass_cnt++;
  endtask

  task automatic test_shadow();
    for (int c = 0; c < 10; c++) begin
      bus.count_val = 16'(c);
      if (c == 5) begin bus.cfg_load = 1'b1; bus.compare1 = 16'd7; end
      tick();
      bus.cfg_load = 1'b0;
      if (c == 5) bus.compare1 = 16'd1;
      total_cnt++;
      if ({bus.pwm_out, bus.cfg_pending} !== {1'(c < 3), 1'(c >= 5)})
        $display("FAIL shadow_hold c=%0d: got %b expected %b", c, {bus.pwm_out, bus.cfg_pending}, {1'(c < 3), 1'(c >= 5)});
      else pass_cnt++;
    end
    for (int c = 0; c < 10; c++) begin
      bus.count_val = 16'(c);
      tick();
      total_cnt++;
      if ({bus.pwm_out, bus.cfg_pending} !== {1'(c < 7), 1'b0})
        $display("FAIL shadow_apply c=%0d: got %b expected %b", c, {bus.pwm_out, bus.cfg_pending}, {1'(c < 7), 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_boundary_load();
    for (int c = 0; c < 10; c++) begin
      bus.count_val = 16'(c);
      if (c == 0) begin bus.cfg_load = 1'b1; bus.compare1 = 16'd2; end
      tick();
      bus.cfg_load = 1'b0;
      total_cnt++;
      if ({bus.pwm_out, bus.period_evt, bus.cfg_pending} !== {1'(c < 2), 1'(c == 0), 1'b0})
        $display("FAIL boundary_load c=%0d: got %b expected %b", c,
                 {bus.pwm_out, bus.period_evt, bus.cfg_pending}, {1'(c < 2), 1'(c == 0), 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_range_down();
    bus.upnotdown = 1'b0;
    bus.functions = 2'b10; bus.compare1 = 16'd4; bus.compare2 = 16'd8;
    for (int c = 8; c >= 0; c--) begin
      bus.count_val = 16'(c);
      bus.cfg_load = (c == 8);
      tick();
      bus.cfg_load = 1'b0;
      total_cnt++;
      if (exp_vec() !== {bus.pwm_out, bus.period_evt, bus.cfg_pending})
        $display("FAIL range_prep c=%0d: got %b expected %b", c, {bus.pwm_out, bus.period_evt, bus.cfg_pending}, exp_vec());
      else pass_cnt++;
    end
    for (int c = 9; c >= 0; c--) begin
      bus.count_val = 16'(c);
      if (c == 0) begin bus.cfg_load = 1'b1; bus.compare1 = 16'd8; bus.compare2 = 16'd4; end
      tick();
      bus.cfg_load = 1'b0;
      total_cnt++;
      if ({bus.pwm_out, bus.period_evt} !== {1'(c >= 4 && c < 8), 1'(c == 9)})
        $display("FAIL range_down c=%0d: got %b expected %b", c, {bus.pwm_out, bus.period_evt}, {1'(c >= 4 && c < 8), 1'(c == 9)});
      else pass_cnt++;
    end
    for (int c = 9; c >= 0; c--) begin
      bus.count_val = 16'(c);
      tick();
      total_cnt++;
      if (bus.pwm_out !== 1'b0)
        $display("FAIL range_inverted c=%0d: got %b expected 0", c, bus.pwm_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_disable_pol();
    bus.upnotdown = 1'b1; bus.pwm_en = 1'b0; bus.polarity = 1'b1;
    bus.functions = 2'b00; bus.compare1 = 16'd0;
    for (int c = 0; c < 10; c++) begin
      bus.count_val = 16'(c);
      tick();
      total_cnt++;
      if ({bus.pwm_out, bus.period_evt, bus.cfg_pending} !== 3'b100)
        $display("FAIL disabled_pol c=%0d: got %b expected 100", c, {bus.pwm_out, bus.period_evt, bus.cfg_pending});
      else pass_cnt++;
    end
    bus.pwm_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.count_val = 16'(c);
      tick();
      total_cnt++;
      if ({bus.pwm_out, bus.period_evt} !== {1'b1, 1'(c == 0)})
        $display("FAIL enabled_cmp0 c=%0d: got %b expected %b", c, {bus.pwm_out, bus.period_evt}, {1'b1, 1'(c == 0)});
      else pass_cnt++;
    end
  endtask

  task automatic test_held_reset();
    int unsigned evts = 0;
    bus.polarity = 1'b0; bus.compare1 = 16'd5;
    for (int c = 5; c < 10; c++) begin
      bus.count_val = 16'(c);
      bus.cfg_load = (c == 5);
      tick();
      bus.cfg_load = 1'b0;
    end
    bus.count_val = '0;
    repeat (5) begin
      tick();
      if (bus.period_evt === 1'b1) evts++;
      total_cnt++;
      if (bus.pwm_out !== 1'b1) $display("FAIL held_pwm: got %b expected 1", bus.pwm_out);
      else pass_cnt++;
    end
    total_cnt++;
    if (evts != 1) $display("FAIL held_evt_count: got %0d expected 1", evts);
    else pass_cnt++;
    for (int c = 1; c < 4; c++) begin
      bus.count_val = 16'(c);
      bus.cfg_load = (c == 2);
      tick();
      bus.cfg_load = 1'b0;
    end
    total_cnt++;
    if ({bus.pwm_out, bus.cfg_pending} !== 2'b11)
      $display("FAIL pre_reset: got %b expected 11", {bus.pwm_out, bus.cfg_pending});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.pwm_out, bus.period_evt, bus.cfg_pending} !== 3'b000)
      $display("FAIL async_reset: got %b expected 000", {bus.pwm_out, bus.period_evt, bus.cfg_pending});
    else pass_cnt++;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 4; c < 14; c++) begin
        bus.count_val = 16'(c % 10);
        tick();
        total_cnt++;
        if (exp_vec() !== {bus.pwm_out, bus.period_evt, bus.cfg_pending})
          $display("FAIL post_reset c=%0d: got %b expected %b", c % 10, {bus.pwm_out, bus.period_evt, bus.cfg_pending}, exp_vec());
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    int unsigned per = 10, c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) per = $urandom_range(0, 12);
      if ($urandom_range(0, 99) < 2) bus.upnotdown = ~bus.upnotdown;
      if ($urandom_range(0, 63) == 0) bus.pwm_en = ~bus.pwm_en;
      if ($urandom_range(0, 3) != 0) begin
        if (per == 0) c = $urandom_range(0, 3);
        else if (bus.upnotdown) c = (c + 1) % per;
        else c = (c == 0 || c >= per) ? per - 1 : c - 1;
      end
      bus.period = 16'(per);
      bus.count_val = 16'(c);
      bus.cfg_load = ($urandom_range(0, 7) == 0);
      bus.compare1 = 16'($urandom_range(0, 14));
      bus.compare2 = 16'($urandom_range(0, 14));
      bus.functions = 2'($urandom_range(0, 3));
      bus.polarity = 1'($urandom_range(0, 1));
      tick();
      total_cnt++;
      if (exp_vec() !== {bus.pwm_out, bus.period_evt, bus.cfg_pending})
        $display("FAIL random i=%0d: got %b expected %b", i, {bus.pwm_out, bus.period_evt, bus.cfg_pending}, exp_vec());
      else pass_cnt++;
    end
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_basic();
    test_shadow();
    test_boundary_load();
    test_range_down();
    test_disable_pol();
    test_held_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
